plate_sequence_lock: RTL and testbench
======================================

# plate_sequence_lock

Phase-4 pressure-plate lock of the vault. It is enabled by the phase-3 maze tracker's done flag and watches the 8-bit plate bus for a fixed three-byte sequence (default 0xAA, 0xCC, 0xF0). On success it raises a sticky `done` that releases the phase-5 time-lock stage. Wrong plates are counted, and repeated failures trigger a timed lockout.

## Interface
- `SEQ0`, default 8'hAA: first required plate pattern.
- `SEQ1`, default 8'hCC: second required plate pattern.
- `SEQ2`, default 8'hF0: third required plate pattern.
- `MAX_FAILS`, default 3: number of mismatches that triggers lockout; legal range 1..3.
- `LOCKOUT_CYCLES`, default 16: lockout duration in clocks; legal range 1..255.

Ports:
- `clk`  in  1  single clock domain; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `enable`  in  1  phase-3 done; the lock is active only while high.
- `plate_in`  in  8  current plate pattern; 8'h00 means no plate pressed.
- `done`  out  1  sequence accepted; sticky until `reset`.
- `fail`  out  1  one-cycle pulse on each mismatch.
- `lockout`  out  1  high while the lockout timer runs.
- `stage`  out  2  matched bytes so far (0..3).
- `fail_count`  out  2  mismatches since the last lockout or reset.

## Operation
- **States:** IDLE, S0 (expect SEQ0), S1 (expect SEQ1), S2 (expect SEQ2), DONE, LOCK.
- **Reset values:** state IDLE, `done`=0, `fail`=0, `lockout`=0, `stage`=0, `fail_count`=0, `prev_plate`=8'h00, lockout counter 0.
- **Press event:** `plate_in` != 8'h00 and `plate_in` != `prev_plate`.
  - `prev_plate` is registered from `plate_in` every cycle in every state.
  - A held pattern therefore produces one event only.
  - Zero gaps are ignored.
- **IDLE:**
  - `enable`=1 → S0.
  - No event in the entry cycle is evaluated; IDLE ignores events.
- **S0, S1, S2, on an event:**
  - Match → next state. S2 match → DONE.
  - Mismatch → `fail` pulses and `fail_count` increments.
    - If the new count equals `MAX_FAILS` → LOCK with the counter loaded to `LOCKOUT_CYCLES`-1.
    - Otherwise → S0.
  - A mismatch in S1 or S2 discards progress.
- **`stage` value:** 0 in IDLE/S0/LOCK, 1 in S1, 2 in S2, 3 in DONE.
- **`enable` deasserted in S0..S2:** → IDLE, progress discarded, `fail_count` retained (anti brute-force).
- **DONE:**
  - Terminal state; `done`=1.
  - All inputs, including `enable`, are ignored until `reset`.
  - `fail_count` is frozen.
- **LOCK:**
  - `lockout`=1; events and `enable` are ignored.
  - The counter decrements each cycle.
  - At 0: `fail_count` clears and the state goes to S0 if `enable`=1, else IDLE.
- **Mismatch defined:** any event whose value is not the expected byte. This includes an earlier sequence byte (e.g. SEQ0 while in S1).

## Timing
- All outputs are registered.
- `done` rises at the clock edge that samples a valid SEQ2 event.
  - Example: SEQ0, SEQ1, SEQ2 on three consecutive cycles in S0 → `done` high after the third edge.
- `fail` is high for exactly the cycle following the mismatching sample edge.
  - `fail_count` updates on the same edge.
- Lockout duration:
  - `lockout` rises on the mismatch edge and stays high for exactly `LOCKOUT_CYCLES` clocks.
  - The first event can be evaluated in the cycle after `lockout` falls.
- `prev_plate` updates during LOCK. A pattern held across the end of lockout is therefore not an event.
- Async `reset` in any state forces all outputs to reset values without waiting for `clk`. Release is synchronous to the next edge.

## Test plan
1. Happy path: reset, `enable`=1, then `plate_in` AA, CC, F0 on consecutive cycles, then F0 held 20 cycles.
   - Required: `stage` 1, 2, 3; `done`=1 after the F0 edge and stays 1; `fail` never pulses.
2. Held and gapped presses: AA held 3 cycles, 00, 00, CC held 2 cycles, 00, F0.
   - Required: no `fail`; `done`=1; `fail_count`=0.
3. Single mismatch: AA, then 55.
   - Required: `fail` pulses one cycle, `fail_count`=1, `stage`=0.
   - Then 00, AA, CC, F0 → `done`=1, `fail_count` stays 1.
4. Lockout: three mismatches (11, 22, 33) with defaults.
   - Required: `lockout` high exactly 16 cycles.
   - AA, CC, F0 presented during lockout are ignored; `stage` stays 0.
   - After lockout: `fail_count`=0, and AA, CC, F0 → `done`.
5. Enable drop: AA accepted, `enable`=0 for 2 cycles, `enable`=1, then CC.
   - Required: `stage` back to 0 after the drop; CC → `fail` pulse.
6. Async reset mid-lockout: assert `reset` between clock edges during lockout.
   - Required: `lockout`, `fail_count`, and `stage` are 0 immediately, before the next `clk` edge.

Source files
------------

// File: rtl/plate_sequence_lock.sv
// Phase-4 pressure-plate lock: accepts a three-byte plate sequence, counts
// mismatches and enforces a timed lockout after MAX_FAILS wrong presses.
module plate_sequence_lock #(
  parameter logic [7:0]  SEQ0           = 8'hAA,
  parameter logic [7:0]  SEQ1           = 8'hCC,
  parameter logic [7:0]  SEQ2           = 8'hF0,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] plate_in,
  output logic       done,
  output logic       fail,
  output logic       lockout,
  output logic [1:0] stage,
  output logic [1:0] fail_count
);

  localparam int unsigned PW = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned FW = 2;
  localparam int unsigned SW = 2;

  localparam logic [CW-1:0] LOCK_LOAD  = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S0   = 3'd1,
    ST_S1   = 3'd2,
    ST_S2   = 3'd3,
    ST_DONE = 3'd4,
    ST_LOCK = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fail_cnt_q, fail_cnt_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic          lockout_q, lockout_d;
  logic [SW-1:0] stage_q, stage_d;

  logic          press;
  logic [PW-1:0] expected;
  logic [FW-1:0] fail_inc;

  // A press is a non-zero pattern that differs from last cycle's pattern.
  assign press    = (plate_in != PW'(0)) && (plate_in != prev_q);
  assign fail_inc = fail_cnt_q + FW'(1);

  always_comb begin
    expected = SEQ0;
    case (state_q)
      ST_S1:   expected = SEQ1;
      ST_S2:   expected = SEQ2;
      default: expected = SEQ0;
    endcase
  end

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fail_cnt_d = fail_cnt_q;
    fail_d     = 1'b0;
    stage_d    = SW'(0);

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_S0;
      end
      ST_S0, ST_S1, ST_S2: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (press) begin
          if (plate_in == expected) begin
            case (state_q)
              ST_S0:   state_d = ST_S1;
              ST_S1:   state_d = ST_S2;
              default: state_d = ST_DONE;
            endcase
          end else begin
            fail_d     = 1'b1;
            fail_cnt_d = fail_inc;
            if (fail_inc == FAIL_LIMIT) begin
              state_d = ST_LOCK;
              cnt_d   = LOCK_LOAD;
            end else begin
              state_d = ST_S0;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      ST_LOCK: begin
        if (cnt_q == CW'(0)) begin
          fail_cnt_d = FW'(0);
          state_d    = enable ? ST_S0 : ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_S1:   stage_d = SW'(1);
      ST_S2:   stage_d = SW'(2);
      ST_DONE: stage_d = SW'(3);
      default: stage_d = SW'(0);
    endcase
    done_d    = (state_d == ST_DONE);
    lockout_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prev_q     <= PW'(0);
      cnt_q      <= CW'(0);
      fail_cnt_q <= FW'(0);
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      lockout_q  <= 1'b0;
      stage_q    <= SW'(0);
    end else begin
      state_q    <= state_d;
      prev_q     <= plate_in;
      cnt_q      <= cnt_d;
      fail_cnt_q <= fail_cnt_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      lockout_q  <= lockout_d;
      stage_q    <= stage_d;
    end
  end

  assign done       = done_q;
  assign fail       = fail_q;
  assign lockout    = lockout_q;
  assign stage      = stage_q;
  assign fail_count = fail_cnt_q;

endmodule

// File: tb/tb_plate_sequence_lock.sv
// Directed bench for plate_sequence_lock: vector table plus hand-written
// lockout and asynchronous-reset sequences.
module tb_plate_sequence_lock;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] plate_in;
  logic       done;
  logic       fail;
  logic       lockout;
  logic [1:0] stage;
  logic [1:0] fail_count;

  int n_cmp = 0;
  int n_bad = 0;

  plate_sequence_lock dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .plate_in   (plate_in),
    .done       (done),
    .fail       (fail),
    .lockout    (lockout),
    .stage      (stage),
    .fail_count (fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] plate;
    logic [1:0] stage;
    logic       done;
    logic       fail;
    logic [1:0] fc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [7:0] p,
                     input logic [1:0] s, input logic d, input logic f,
                     input logic [1:0] c);
    vec_t v;
    v.rst = r; v.en = e; v.plate = p; v.stage = s; v.done = d; v.fail = f; v.fc = c;
    vecs.push_back(v);
  endtask

  // Asserts reset off-edge, checks outputs clear before any clock edge, releases.
  task automatic do_reset(input string tag);
    reset    = 1'b1;
    enable   = 1'b0;
    plate_in = 8'h00;
    #1;
    check({tag, " reset done"},    int'(done),       0);
    check({tag, " reset fail"},    int'(fail),       0);
    check({tag, " reset lockout"}, int'(lockout),    0);
    check({tag, " reset stage"},   int'(stage),      0);
    check({tag, " reset fc"},      int'(fail_count), 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic step(input logic e, input logic [7:0] p);
    enable   = e;
    plate_in = p;
    @(posedge clk); #1;
  endtask

  initial begin
    int lock_n;
    bit fell;

    reset    = 1'b1;
    enable   = 1'b0;
    plate_in = 8'h00;
    @(posedge clk); #1;

    // Happy path, then DONE ignores enable drop and further presses.
    add(1,1,8'h00,0,0,0,0);
    add(0,1,8'hAA,1,0,0,0);
    add(0,1,8'hCC,2,0,0,0);
    add(0,1,8'hF0,3,1,0,0);
    for (int i = 0; i < 20; i++) add(0,1,8'hF0,3,1,0,0);
    add(0,0,8'h11,3,1,0,0);
    add(0,1,8'hAA,3,1,0,0);
    // Held and gapped presses.
    add(1,1,8'h00,0,0,0,0);
    add(0,1,8'hAA,1,0,0,0);
    add(0,1,8'hAA,1,0,0,0);
    add(0,1,8'hAA,1,0,0,0);
    add(0,1,8'h00,1,0,0,0);
    add(0,1,8'h00,1,0,0,0);
    add(0,1,8'hCC,2,0,0,0);
    add(0,1,8'hCC,2,0,0,0);
    add(0,1,8'h00,2,0,0,0);
    add(0,1,8'hF0,3,1,0,0);
    // Single mismatch, then recovery with fail_count frozen at 1.
    add(1,1,8'h00,0,0,0,0);
    add(0,1,8'hAA,1,0,0,0);
    add(0,1,8'h55,0,0,1,1);
    add(0,1,8'h00,0,0,0,1);
    add(0,1,8'hAA,1,0,0,1);
    add(0,1,8'hCC,2,0,0,1);
    add(0,1,8'hF0,3,1,0,1);
    // Enable drop discards progress but keeps fail_count.
    add(1,1,8'h00,0,0,0,0);
    add(0,1,8'hAA,1,0,0,0);
    add(0,0,8'h00,0,0,0,0);
    add(0,0,8'h00,0,0,0,0);
    add(0,1,8'h00,0,0,0,0);
    add(0,1,8'hCC,0,0,1,1);
    add(0,0,8'h00,0,0,0,1);
    add(0,1,8'h00,0,0,0,1);
    // Earlier sequence byte while in S1 is a mismatch.
    add(1,1,8'h00,0,0,0,0);
    add(0,1,8'hAA,1,0,0,0);
    add(0,1,8'h00,1,0,0,0);
    add(0,1,8'hAA,0,0,1,1);
    // IDLE and the entry cycle ignore presses.
    add(1,0,8'hAA,0,0,0,0);
    add(0,1,8'h55,0,0,0,0);
    add(0,1,8'h00,0,0,0,0);
    add(0,1,8'h55,0,0,1,1);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset($sformatf("v%0d", i));
      step(vecs[i].en, vecs[i].plate);
      check($sformatf("v%0d stage", i),   int'(stage),      int'(vecs[i].stage));
      check($sformatf("v%0d done", i),    int'(done),       int'(vecs[i].done));
      check($sformatf("v%0d fail", i),    int'(fail),       int'(vecs[i].fail));
      check($sformatf("v%0d fc", i),      int'(fail_count), int'(vecs[i].fc));
      check($sformatf("v%0d lockout", i), int'(lockout),    0);
    end

    // Lockout after three mismatches; presses during lockout are ignored.
    do_reset("lock");
    step(1'b1, 8'h00);
    step(1'b1, 8'h11);
    check("lock fc1", int'(fail_count), 1);
    step(1'b1, 8'h22);
    check("lock fc2", int'(fail_count), 2);
    check("lock no lockout yet", int'(lockout), 0);
    step(1'b1, 8'h33);
    check("lock fail pulse", int'(fail), 1);
    check("lock fc3", int'(fail_count), 3);
    check("lock rise", int'(lockout), 1);
    lock_n = 1;
    step(1'b1, 8'hAA);
    check("lock fail one cycle", int'(fail), 0);
    if (lockout) lock_n++;
    step(1'b1, 8'hCC);
    if (lockout) lock_n++;
    step(1'b1, 8'hF0);
    if (lockout) lock_n++;
    check("lock ignores stage", int'(stage), 0);
    check("lock ignores done",  int'(done),  0);
    fell = 1'b0;
    for (int i = 0; i < 40 && !fell; i++) begin
      step(1'b1, 8'h00);
      if (lockout) lock_n++;
      else fell = 1'b1;
    end
    check("lock fell within bound", int'(fell), 1);
    check("lock duration", lock_n, 16);
    check("lock fc cleared", int'(fail_count), 0);
    check("lock exit stage", int'(stage), 0);
    step(1'b1, 8'hAA);
    check("post-lock stage1", int'(stage), 1);
    step(1'b1, 8'hCC);
    check("post-lock stage2", int'(stage), 2);
    step(1'b1, 8'hF0);
    check("post-lock done", int'(done), 1);
    check("post-lock stage3", int'(stage), 3);

    // Asynchronous reset in the middle of lockout.
    do_reset("arst pre");
    step(1'b1, 8'h00);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    check("arst lockout before", int'(lockout), 1);
    check("arst fc before", int'(fail_count), 3);
    #2;
    do_reset("arst mid-lock");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
